// File: rtl/nested_select_seq.sv
// nested_select_seq
//   Code register with a hold-run sequencer. In IDLE the code b either loads
//   code_in (starting a run), increments, or falls back to the idle code.
//   A run holds b for HOLD_CYCLES cycles, then spends one DRAIN cycle
//   (done=1) before returning to IDLE. Dropping a during RUN aborts the run
//   without a done pulse.
//
// Ports
//   clock   : single clock, rising edge
//   reset   : synchronous, active-high
//   a       : primary qualifier (0 = idle code / abort)
//   en      : load enable, sampled only in IDLE with a=1
//   code_in : value loaded into b
//   b       : current code (registered)
//   d       : previous value of b (registered)
//   busy    : state is not IDLE
//   done    : state is DRAIN
module nested_select_seq #(
    parameter int WIDTH       = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int DEFAULT_B   = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             a,
    input  logic             en,
    input  logic [WIDTH-1:0] code_in,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] d,
    output logic             busy,
    output logic             done
);

    // Counter only has to hold HOLD_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [WIDTH-1:0] IDLE_CODE = WIDTH'(DEFAULT_B);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            b     <= '0;
            d     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    d <= b;
                    if (!a) begin
                        b <= IDLE_CODE;
                    end else if (en) begin
                        b     <= code_in;
                        cnt   <= CNT_LOAD;
                        state <= RUN;
                    end else begin
                        // Wraps modulo 2^WIDTH by truncation.
                        b <= b + 1'b1;
                    end
                end
                RUN: begin
                    // Abort is checked first so it wins over counter expiry.
                    if (!a) begin
                        b     <= IDLE_CODE;
                        d     <= b;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DRAIN);

endmodule

// File: tb/tb_nested_select_seq.sv
module tb_nested_select_seq;

    localparam int WIDTH = 2;
    localparam int HOLD  = 4;
    localparam int DEFB  = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             a = 1'b0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] code_in = '0;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    logic             busy;
    logic             done;

    int vectors = 0;
    int miscompares = 0;

    nested_select_seq #(
        .WIDTH(WIDTH),
        .HOLD_CYCLES(HOLD),
        .DEFAULT_B(DEFB)
    ) dut (
        .clock(clk),
        .reset(reset),
        .a(a),
        .en(en),
        .code_in(code_in),
        .b(b),
        .d(d),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             a;
        logic             en;
        logic [WIDTH-1:0] code;
        logic [WIDTH-1:0] eb;
        logic [WIDTH-1:0] ed;
        logic             ebusy;
        logic             edone;
    } vec_t;

    vec_t tbl[15];

    // Behavioural reference: run length in cycles left, plus a drain flag.
    int               m_run_left;
    bit               m_drain;
    logic [WIDTH-1:0] m_b;
    logic [WIDTH-1:0] m_d;

    task automatic model_step(input logic r, input logic ia, input logic ien,
                              input logic [WIDTH-1:0] ic);
        if (r) begin
            m_b = '0; m_d = '0; m_run_left = 0; m_drain = 0;
        end else if (m_drain) begin
            m_drain = 0;
        end else if (m_run_left > 0) begin
            if (!ia) begin
                m_d = m_b;
                m_b = WIDTH'(DEFB);
                m_run_left = 0;
            end else begin
                m_run_left = m_run_left - 1;
                if (m_run_left == 0) m_drain = 1;
            end
        end else begin
            m_d = m_b;
            if (!ia) m_b = WIDTH'(DEFB);
            else if (ien) begin
                m_b = ic;
                m_run_left = HOLD;
            end else m_b = WIDTH'((int'(m_b) + 1) % (1 << WIDTH));
        end
    endtask

    task automatic cyc(input logic r, input logic ia, input logic ien,
                       input logic [WIDTH-1:0] ic);
        reset = r; a = ia; en = ien; code_in = ic;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [WIDTH-1:0] eb,
                       input logic [WIDTH-1:0] ed, input logic ebusy,
                       input logic edone);
        vectors++;
        if (b !== eb || d !== ed || busy !== ebusy || done !== edone) begin
            miscompares++;
            $display("FAIL %s: got b=%0d d=%0d busy=%0b done=%0b, want b=%0d d=%0d busy=%0b done=%0b",
                     name, b, d, busy, done, eb, ed, ebusy, edone);
        end
    endtask

    initial begin
        bit done_seen;
        logic r, ra, ren;
        logic [WIDTH-1:0] rc;

        // reset, load 2, 4 RUN + 1 DRAIN, ignore inputs in DRAIN,
        // idle code from b=2, then reset and increment with wrap.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 2'd2, 2'd2, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 2'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 2'd1, 2'd2, 2'd0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 2'd0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 2'd0, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd2, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd3, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 2'd1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 2'd2, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].rst, tbl[i].a, tbl[i].en, tbl[i].code);
            chk($sformatf("table[%0d]", i), tbl[i].eb, tbl[i].ed,
                tbl[i].ebusy, tbl[i].edone);
        end

        // Abort on 2nd RUN cycle: no done afterwards.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 1);  chk("abort2_load", 2'd1, 2'd0, 1, 0);
        cyc(0, 1, 0, 0);  chk("abort2_run1", 2'd1, 2'd0, 1, 0);
        cyc(0, 0, 0, 0);  chk("abort2_abort", 2'd3, 2'd1, 0, 0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 0);
            if (done) done_seen = 1;
        end
        vectors++;
        if (done_seen) begin
            miscompares++;
            $display("FAIL abort2_nodone: got done=1, want done=0");
        end

        // Abort in the cnt==0 cycle: abort beats expiry, no DRAIN.
        cyc(0, 1, 1, 2);  chk("abort4_load", 2'd2, 2'd3, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);  chk("abort4_run3", 2'd2, 2'd3, 1, 0);
        cyc(0, 0, 0, 0);  chk("abort4_abort", 2'd3, 2'd2, 0, 0);
        cyc(0, 0, 0, 0);  chk("abort4_after", 2'd3, 2'd3, 0, 0);

        // Reset in RUN, then reset in DRAIN.
        cyc(0, 1, 1, 1);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);  chk("reset_in_run", 2'd0, 2'd0, 0, 0);
        cyc(0, 1, 1, 2);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        chk("drain_reached", 2'd2, 2'd0, 1, 1);
        cyc(1, 1, 1, 1);  chk("reset_in_drain", 2'd0, 2'd0, 0, 0);

        // Randomized run against the reference model.
        cyc(1, 0, 0, 0);
        model_step(1, 0, 0, 0);
        for (int i = 0; i < 500; i++) begin
            r   = ($urandom_range(0, 29) == 0);
            ra  = ($urandom_range(0, 5) != 0);
            ren = $urandom_range(0, 1);
            rc  = WIDTH'($urandom);
            cyc(r, ra, ren, rc);
            model_step(r, ra, ren, rc);
            chk($sformatf("rand[%0d]", i), m_b, m_d,
                (m_run_left > 0) || m_drain, m_drain);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nested_select_seq.md
NESTED_SELECT_SEQ -- requirements
Module: nested_select_seq

Interface
REQ-001 Parameter WIDTH, default 2, bit width of b, d and code_in; legal range is 1 to 16.
REQ-002 Parameter HOLD_CYCLES, default 4, number of RUN cycles per load; legal range is 1 to 255.
REQ-003 Parameter DEFAULT_B, default 3, idle code; it is truncated to WIDTH bits.
REQ-004 Port clock  input  1  is the single clock; all state updates occur on its rising edge.
REQ-005 Port reset  input  1  is the reset; it is synchronous and active-high.
REQ-006 Port a  input  1  is the primary qualifier; a=0 forces the idle code or aborts a run.
REQ-007 Port en  input  1  is the load enable; it is sampled only in IDLE with a=1.
REQ-008 Port code_in  input  WIDTH  is the code value captured into b on a load.
REQ-009 Port b  output  WIDTH  is the current code; it is driven directly from a register.
REQ-010 Port d  output  WIDTH  is the previous value of b; it is driven directly from a register.
REQ-011 Port busy  output  1  is high whenever the state is not IDLE.
REQ-012 Port done  output  1  is high for exactly the single DRAIN cycle that ends a completed run.

Function
REQ-013 The block SHALL implement three states: IDLE, RUN and DRAIN, encoded in a state register.
REQ-014 The block SHALL include a down-counter cnt that is wide enough to hold HOLD_CYCLES-1.
REQ-015 In IDLE with a=1 and en=1, the next edge SHALL set b<=code_in, d<=b, cnt<=HOLD_CYCLES-1 and state<=RUN.
REQ-016 In IDLE with a=1 and en=0, the next edge SHALL set b<=(b+1) mod 2^WIDTH and d<=b, and the state SHALL stay IDLE.
REQ-017 In IDLE with a=0, the next edge SHALL set b<=DEFAULT_B and d<=b, and the state SHALL stay IDLE.
REQ-018 In RUN with a=1, b and d SHALL hold; if cnt==0 then state<=DRAIN, otherwise cnt<=cnt-1.
REQ-019 In RUN with a=0, the block SHALL abort: b<=DEFAULT_B, d<=b, cnt<=0, state<=IDLE, and done SHALL never assert for that run.
REQ-020 An abort SHALL take priority over counter expiry when a=0 and cnt==0 occur in the same cycle.
REQ-021 In DRAIN, a, en and code_in SHALL be ignored, b and d SHALL hold, and the next state SHALL be IDLE.
REQ-022 busy SHALL be (state!=IDLE) and done SHALL be (state==DRAIN); both are decoded combinationally from the state register.
REQ-023 Load-to-done latency SHALL be HOLD_CYCLES+1 cycles: RUN lasts HOLD_CYCLES cycles and DRAIN lasts 1 cycle.
REQ-024 The increment in REQ-016 SHALL wrap from 2^WIDTH-1 to 0 with no flag.
REQ-025 With HOLD_CYCLES=1, the block SHALL spend exactly one cycle in RUN before DRAIN.
REQ-026 A new load SHALL be accepted no earlier than the first IDLE cycle after DRAIN; there are no back-to-back runs without passing through IDLE.
REQ-027 Every register SHALL be written in exactly one clocked process, with no latches and no procedural continuous assigns.

Reset
REQ-028 When reset=1 at a rising edge, the next state SHALL be b=0, d=0, cnt=0 and state=IDLE, so busy=0 and done=0.
REQ-029 Reset SHALL override every other input in every state, including in the middle of RUN and during DRAIN.
REQ-030 The first transition after reset deasserts SHALL follow REQ-015 to REQ-017 based on the inputs sampled at that edge.

Verification (WIDTH=2, HOLD_CYCLES=4, DEFAULT_B=3)
REQ-031 Reset, then hold a=1, en=1, code_in=2 for one cycle -> b=2 and d=0 one cycle later, busy high for 5 cycles, done high on the 5th cycle only, then IDLE.
REQ-032 In IDLE from b=0, hold a=1, en=0 for 5 cycles -> b steps 1,2,3,0,1 and d lags b by one cycle.
REQ-033 Load code_in=1, then drop a on the 2nd RUN cycle -> the next cycle shows b=3, d=1, busy=0, and done never asserts.
REQ-034 Load, then drop a on the 4th RUN cycle (the cnt==0 cycle) -> the block aborts to IDLE with b=3 and no DRAIN cycle.
REQ-035 Assert reset during RUN and again during DRAIN -> the next cycle shows b=0, d=0, busy=0, done=0.
REQ-036 Hold a=0 from b=2 -> b=3 and d=2 after 1 cycle, then b=3 and d=3 after 2 cycles.
